// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the ALU: buffers commands in a FIFO, issues them one at a
// time on registered drive lines and holds each tagged result until it is accepted.
module alu_cmd_sequencer #(
    parameter int unsigned N     = 4,
    parameter int unsigned M     = 8,
    parameter int unsigned K     = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TW    = 3
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [N-1:0]  i_cmd_op,
    input  logic [M-1:0]  i_cmd_A,
    input  logic [M-1:0]  i_cmd_B,
    output logic [TW-1:0] o_cmd_tag,
    output logic [N-1:0]  o_alu_op,
    output logic [M-1:0]  o_alu_A,
    output logic [M-1:0]  o_alu_B,
    input  logic [K-1:0]  i_alu_result,
    input  logic [3:0]    i_alu_status,
    output logic          o_res_valid,
    input  logic          i_res_ready,
    output logic [K-1:0]  o_result,
    output logic [3:0]    o_status,
    output logic [TW-1:0] o_res_tag,
    output logic          o_busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = N + 2 * M + TW;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPT, S_HOLD} state_t;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [TW-1:0] tag_q, iss_tag_q;
    state_t        state_q;

    logic [N-1:0]  alu_op_q;
    logic [M-1:0]  alu_a_q, alu_b_q;
    logic          res_valid_q;
    logic [K-1:0]  result_q;
    logic [3:0]    status_q;
    logic [TW-1:0] res_tag_q;

    logic push_c, pop_c, empty_c;

    assign empty_c     = (count_q == '0);
    assign o_cmd_ready = (count_q != CW'(DEPTH));
    assign push_c      = i_cmd_valid && o_cmd_ready;
    // Issue from IDLE, or straight out of HOLD on the accept edge.
    assign pop_c       = !empty_c && ((state_q == S_IDLE) ||
                                      ((state_q == S_HOLD) && i_res_ready));

    assign o_cmd_tag   = tag_q;
    assign o_alu_op    = alu_op_q;
    assign o_alu_A     = alu_a_q;
    assign o_alu_B     = alu_b_q;
    assign o_res_valid = res_valid_q;
    assign o_result    = result_q;
    assign o_status    = status_q;
    assign o_res_tag   = res_tag_q;
    assign o_busy      = !empty_c || (state_q != S_IDLE);

    // FIFO storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge i_clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= {i_cmd_op, i_cmd_A, i_cmd_B, tag_q};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tag_q       <= '0;
            iss_tag_q   <= '0;
            state_q     <= S_IDLE;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            res_valid_q <= 1'b0;
            result_q    <= '0;
            status_q    <= '0;
            res_tag_q   <= '0;
        end else begin
            count_q <= count_q + CW'(push_c) - CW'(pop_c);
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
                tag_q    <= tag_q + TW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                {alu_op_q, alu_a_q, alu_b_q, iss_tag_q} <= mem_q[rd_ptr_q];
            end
            case (state_q)
                S_IDLE: if (pop_c) state_q <= S_WAIT;
                S_WAIT: state_q <= S_CAPT;
                S_CAPT: begin
                    result_q    <= i_alu_result;
                    status_q    <= i_alu_status;
                    res_tag_q   <= iss_tag_q;
                    res_valid_q <= 1'b1;
                    state_q     <= S_HOLD;
                end
                S_HOLD: begin
                    if (i_res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= pop_c ? S_WAIT : S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a registered ALU stand-in.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = '0;
    logic [7:0] cmd_a = '0, cmd_b = '0;
    logic [2:0] cmd_tag;
    logic [3:0] alu_op;
    logic [7:0] alu_a, alu_b;
    logic [7:0] alu_res = '0;
    logic [3:0] alu_st = '0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] result;
    logic [3:0] status;
    logic [2:0] res_tag;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    alu_cmd_sequencer dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_op(cmd_op), .i_cmd_A(cmd_a), .i_cmd_B(cmd_b), .o_cmd_tag(cmd_tag),
        .o_alu_op(alu_op), .o_alu_A(alu_a), .o_alu_B(alu_b),
        .i_alu_result(alu_res), .i_alu_status(alu_st),
        .o_res_valid(res_valid), .i_res_ready(res_ready),
        .o_result(result), .o_status(status), .o_res_tag(res_tag), .o_busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        if (op[3]) return 8'h00;
        case (op[2:0])
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [3:0] st_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        return {2'b00, op[3], (alu_f(op, a, b) == 8'h00)};
    endfunction

    // ALU stand-in: output registered one edge after the drive lines.
    always @(posedge clk) begin
        alu_res <= alu_f(alu_op, alu_a, alu_b);
        alu_st  <= st_f(alu_op, alu_a, alu_b);
    end

    task automatic check(input string tg, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tg, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        while (!cmd_ready && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) check("push_timeout", 32'd0, 32'd1);
        else tick();
        cmd_valid = 1'b0;
    endtask

    // Waits for a result, checks it, and steps past the accept edge (res_ready must be high).
    task automatic collect(input string nm, input logic [7:0] er, input logic [3:0] es,
                           input logic [2:0] et, output int at);
        int n;
        at = -1;
        for (n = 0; n < 30; n++) begin
            if (res_valid) begin
                check({nm, "_result"}, 32'(result), 32'(er));
                check({nm, "_status"}, 32'(status), 32'(es));
                check({nm, "_tag"}, 32'(res_tag), 32'(et));
                at = cyc;
                tick();
                return;
            end
            tick();
        end
        check({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    int t_at;
    int t_prev;
    int highs;

    initial begin
        // Reset state
        do_reset();
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tag", 32'(cmd_tag), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);

        // Single command latency: push at E0, issue at E1, capture at E3
        push(4'b0001, 8'd3, 8'd4);
        check("s_busy_e0", 32'(busy), 32'd1);
        check("s_tag_e0", 32'(cmd_tag), 32'd1);
        tick();
        check("s_alu_a_e1", 32'(alu_a), 32'd3);
        check("s_alu_op_e1", 32'(alu_op), 32'd1);
        check("s_valid_e1", 32'(res_valid), 32'd0);
        tick();
        check("s_valid_e2", 32'(res_valid), 32'd0);
        tick();
        check("s_valid_e3", 32'(res_valid), 32'd1);
        check("s_result_e3", 32'(result), 32'd7);
        check("s_rtag_e3", 32'(res_tag), 32'd0);
        res_ready = 1'b1;
        tick();
        check("s_valid_acc", 32'(res_valid), 32'd0);
        check("s_busy_acc", 32'(busy), 32'd0);
        check("s_alu_a_hold", 32'(alu_a), 32'd3);

        // Fill: one command in flight plus four queued makes the FIFO full
        do_reset();
        for (int i = 0; i < 5; i++) push(4'b0001, 8'(i * 10), 8'(i));
        check("f_ready_full", 32'(cmd_ready), 32'd0);
        check("f_tag_full", 32'(cmd_tag), 32'd5);
        cmd_valid = 1'b1;
        cmd_op = 4'b0001;
        cmd_a = 8'd99;
        cmd_b = 8'd1;
        tick();
        tick();
        tick();
        check("f_tag_ignored", 32'(cmd_tag), 32'd5);
        check("f_ready_still", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) collect("fill", 8'(i * 11), 4'(i == 0), 3'(i), t_at);
        check("f_busy_end", 32'(busy), 32'd0);

        // Stream ten commands with the consumer always ready: tags wrap, one per 3 cycles
        do_reset();
        res_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    push(4'(1 + (i % 4)), 8'(i * 7 + 1), 8'(i + 2));
            end
            begin
                t_prev = -1;
                for (int j = 0; j < 10; j++) begin
                    collect("stream",
                            alu_f(4'(1 + (j % 4)), 8'(j * 7 + 1), 8'(j + 2)),
                            st_f(4'(1 + (j % 4)), 8'(j * 7 + 1), 8'(j + 2)),
                            3'(j), t_at);
                    if (j > 0) check("stream_spacing", 32'(t_at - t_prev), 32'd3);
                    t_prev = t_at;
                end
            end
        join

        // Consumer stall in HOLD: captured result stays put, next issue on the release edge
        do_reset();
        push(4'b0001, 8'd5, 8'd6);
        highs = 0;
        while (!res_valid && highs < 10) begin
            tick();
            highs++;
        end
        push(4'b0010, 8'd20, 8'd3);
        push(4'b0011, 8'd12, 8'd10);
        for (int i = 0; i < 5; i++) begin
            check("h_result", 32'(result), 32'd11);
            check("h_tag", 32'(res_tag), 32'd0);
            check("h_valid", 32'(res_valid), 32'd1);
            tick();
        end
        res_ready = 1'b1;
        tick();
        check("h_valid_rel", 32'(res_valid), 32'd0);
        check("h_alu_a_rel", 32'(alu_a), 32'd20);
        check("h_alu_op_rel", 32'(alu_op), 32'd2);
        collect("hold_b", 8'd17, 4'h0, 3'd1, t_at);
        collect("hold_c", 8'd8, 4'h0, 3'd2, t_at);

        // Reset while waiting on the ALU drops the command
        do_reset();
        push(4'b0001, 8'd1, 8'd1);
        tick();
        check("r_alu_a", 32'(alu_a), 32'd1);
        rst_n = 1'b0;
        tick();
        check("r_valid", 32'(res_valid), 32'd0);
        check("r_busy", 32'(busy), 32'd0);
        check("r_ready", 32'(cmd_ready), 32'd1);
        check("r_tag", 32'(cmd_tag), 32'd0);
        rst_n = 1'b1;
        res_ready = 1'b1;
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (res_valid) highs++;
        end
        check("r_no_stale", 32'(highs), 32'd0);

        // Opcode with bit 3 set passes through; ALU returns zero with status bit 1
        do_reset();
        res_ready = 1'b1;
        push(4'b1000, 8'hFF, 8'h01);
        check("p_alu_op_pre", 32'(alu_op), 32'd0);
        tick();
        check("p_alu_op", 32'(alu_op), 32'd8);
        collect("pass", 8'h00, 4'h3, 3'd0, t_at);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d checks expected completion", n_checks);
        $fatal(1, "timeout");
    end

endmodule
